// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings for the memory port arbiter
// State codes, MS size codes and requester identifiers.
package mem_arb_pkg;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BUSY_F  = 2'd1;
  localparam logic [1:0] S_BUSY_D  = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = S_IDLE,
    ST_BUSY_F  = S_BUSY_F,
    ST_BUSY_D  = S_BUSY_D,
    ST_RELEASE = S_RELEASE
  } arb_state_t;

  localparam logic [2:0] MS_BYTE  = 3'b000;
  localparam logic [2:0] MS_HALF  = 3'b001;
  localparam logic [2:0] MS_WORD  = 3'b010;
  localparam logic [2:0] MS_DWORD = 3'b011;

  localparam logic REQ_F = 1'b0;
  localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/arb_timeout_counter.sv
// rtl/arb_timeout_counter.sv - watchdog counter for outstanding memory accesses
// Counts busy cycles without MOC; expired flags the last legal wait cycle.
module arb_timeout_counter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 8'd0;
    end else if (clr) begin
      count_q <= 8'd0;
    end else if (en) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign expired = (count_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter and MOV/MOC sequencer for ram256x8
// All memory-side and requester-side outputs are registered.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        F_REQ,
  input  logic [31:0] F_ADDR,
  output logic        F_DONE,
  output logic [31:0] F_RDATA,
  input  logic        D_REQ,
  input  logic        D_RW,
  input  logic [2:0]  D_MS,
  input  logic [31:0] D_ADDR,
  input  logic [31:0] D_WDATA,
  output logic        D_DONE,
  output logic [31:0] D_RDATA,
  output logic        ERR,
  output logic        ERR_SRC,
  output logic        MEM_MOV,
  output logic        MEM_RW,
  output logic [2:0]  MEM_MS,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  input  logic        MEM_MOC,
  input  logic [31:0] MEM_DOUT
);

  arb_state_t state_q, state_d;
  logic       last_q;
  logic       grant_f, grant_d, finish, abort;
  logic       busy, expired;

  assign busy = (state_q == ST_BUSY_F) || (state_q == ST_BUSY_D);

  arb_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (CLK),
    .rst_n   (RESET),
    .clr     (grant_f | grant_d),
    .en      (busy && !MEM_MOC),
    .expired (expired)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // MOC is tested before expiry so a late acknowledge still completes cleanly.
  always_comb begin
    state_d = state_q;
    grant_f = 1'b0;
    grant_d = 1'b0;
    finish  = 1'b0;
    abort   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (D_REQ && (!F_REQ || last_q == REQ_F)) begin
          grant_d = 1'b1;
          state_d = ST_BUSY_D;
        end else if (F_REQ) begin
          grant_f = 1'b1;
          state_d = ST_BUSY_F;
        end
      end
      ST_BUSY_F, ST_BUSY_D: begin
        if (MEM_MOC) begin
          finish  = 1'b1;
          state_d = ST_RELEASE;
        end else if (expired) begin
          abort   = 1'b1;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!MEM_MOC) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      last_q    <= REQ_F;
      MEM_MOV   <= 1'b0;
      MEM_RW    <= 1'b0;
      MEM_MS    <= 3'b000;
      MEM_ADDR  <= 32'd0;
      MEM_WDATA <= 32'd0;
      F_DONE    <= 1'b0;
      D_DONE    <= 1'b0;
      F_RDATA   <= 32'd0;
      D_RDATA   <= 32'd0;
      ERR       <= 1'b0;
      ERR_SRC   <= 1'b0;
    end else begin
      F_DONE <= 1'b0;
      D_DONE <= 1'b0;
      ERR    <= 1'b0;
      if (grant_d) begin
        MEM_MOV   <= 1'b1;
        MEM_RW    <= D_RW;
        MEM_MS    <= D_MS;
        MEM_ADDR  <= D_ADDR;
        MEM_WDATA <= D_WDATA;
        last_q    <= REQ_D;
      end
      if (grant_f) begin
        MEM_MOV   <= 1'b1;
        MEM_RW    <= 1'b1;
        MEM_MS    <= MS_WORD;
        MEM_ADDR  <= F_ADDR;
        MEM_WDATA <= 32'd0;
        last_q    <= REQ_F;
      end
      if (finish || abort) begin
        MEM_MOV <= 1'b0;
        F_DONE  <= (state_q == ST_BUSY_F);
        D_DONE  <= (state_q == ST_BUSY_D);
      end
      if (finish && MEM_RW) begin
        if (state_q == ST_BUSY_F) begin
          F_RDATA <= MEM_DOUT;
        end else begin
          D_RDATA <= MEM_DOUT;
        end
      end
      if (abort) begin
        ERR     <= 1'b1;
        ERR_SRC <= (state_q == ST_BUSY_D) ? REQ_D : REQ_F;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
// Inputs change 1 time unit after a rising edge; outputs are checked there.
module tb_mem_port_arbiter;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        F_REQ = 1'b0;
  logic [31:0] F_ADDR = 32'd0;
  logic        F_DONE;
  logic [31:0] F_RDATA;
  logic        D_REQ = 1'b0;
  logic        D_RW = 1'b0;
  logic [2:0]  D_MS = 3'd0;
  logic [31:0] D_ADDR = 32'd0;
  logic [31:0] D_WDATA = 32'd0;
  logic        D_DONE;
  logic [31:0] D_RDATA;
  logic        ERR;
  logic        ERR_SRC;
  logic        MEM_MOV;
  logic        MEM_RW;
  logic [2:0]  MEM_MS;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_WDATA;
  logic        MEM_MOC = 1'b0;
  logic [31:0] MEM_DOUT = 32'd0;

  int total = 0;
  int bad = 0;
  int mov_cycles;
  logic [31:0] exp_drdata;

  mem_port_arbiter #(.TIMEOUT(16)) dut (
    .CLK(CLK), .RESET(RESET),
    .F_REQ(F_REQ), .F_ADDR(F_ADDR), .F_DONE(F_DONE), .F_RDATA(F_RDATA),
    .D_REQ(D_REQ), .D_RW(D_RW), .D_MS(D_MS), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
    .D_DONE(D_DONE), .D_RDATA(D_RDATA), .ERR(ERR), .ERR_SRC(ERR_SRC),
    .MEM_MOV(MEM_MOV), .MEM_RW(MEM_RW), .MEM_MS(MEM_MS), .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA), .MEM_MOC(MEM_MOC), .MEM_DOUT(MEM_DOUT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Acknowledge after wait_cycles idle edges; leaves the bench on the DONE cycle.
  task automatic ack(input int wait_cycles, input logic [31:0] dout);
    for (int i = 0; i < wait_cycles; i++) tick();
    MEM_MOC  = 1'b1;
    MEM_DOUT = dout;
    tick();
    MEM_MOC = 1'b0;
  endtask

  initial begin
    // reset state
    tick();
    check("rst_mov", 32'(MEM_MOV), 32'd0);
    check("rst_ms", 32'(MEM_MS), 32'd0);
    check("rst_frdata", F_RDATA, 32'd0);
    check("rst_drdata", D_RDATA, 32'd0);
    check("rst_errsrc", 32'(ERR_SRC), 32'd0);
    RESET = 1'b1;
    tick();

    // single fetch
    F_REQ = 1'b1; F_ADDR = 32'h10;
    tick();
    F_REQ = 1'b0;
    check("f_mov", 32'(MEM_MOV), 32'd1);
    check("f_rw", 32'(MEM_RW), 32'd1);
    check("f_ms", 32'(MEM_MS), 32'b010);
    check("f_addr", MEM_ADDR, 32'h10);
    ack(2, 32'hE1A0_0000);
    check("f_done", 32'(F_DONE), 32'd1);
    check("f_mov_off", 32'(MEM_MOV), 32'd0);
    check("f_rdata", F_RDATA, 32'hE1A0_0000);
    tick();
    check("f_done_pulse", 32'(F_DONE), 32'd0);
    F_REQ = 1'b1; F_ADDR = 32'h14;
    tick();
    F_REQ = 1'b0;
    check("f2_regrant", 32'(MEM_MOV), 32'd1);
    check("f2_addr", MEM_ADDR, 32'h14);
    ack(0, 32'h0000_0014);
    check("f2_rdata", F_RDATA, 32'h0000_0014);
    tick();

    // tie after reset: data, fetch, data
    RESET = 1'b0;
    tick();
    RESET = 1'b1;
    F_REQ = 1'b1; F_ADDR = 32'h200;
    D_REQ = 1'b1; D_RW = 1'b1; D_MS = 3'b010; D_ADDR = 32'h100;
    tick();
    check("tie1_addr", MEM_ADDR, 32'h100);
    ack(0, 32'h1111_1111);
    check("tie1_ddone", 32'(D_DONE), 32'd1);
    check("tie1_fdone", 32'(F_DONE), 32'd0);
    check("tie1_drdata", D_RDATA, 32'h1111_1111);
    tick();
    check("tie_gap_mov", 32'(MEM_MOV), 32'd0);
    tick();
    check("tie2_addr", MEM_ADDR, 32'h200);
    check("tie2_mov", 32'(MEM_MOV), 32'd1);
    ack(0, 32'h2222_2222);
    check("tie2_fdone", 32'(F_DONE), 32'd1);
    tick();
    tick();
    check("tie3_addr", MEM_ADDR, 32'h100);
    ack(0, 32'h3333_3333);
    F_REQ = 1'b0; D_REQ = 1'b0;
    check("tie3_ddone", 32'(D_DONE), 32'd1);
    exp_drdata = 32'h3333_3333;
    tick();

    // store
    D_REQ = 1'b1; D_RW = 1'b0; D_MS = 3'b000; D_ADDR = 32'h20; D_WDATA = 32'hAB;
    tick();
    D_REQ = 1'b0;
    check("st_wdata", MEM_WDATA, 32'hAB);
    check("st_rw", 32'(MEM_RW), 32'd0);
    check("st_ms", 32'(MEM_MS), 32'd0);
    ack(1, 32'hDEAD_BEEF);
    check("st_ddone", 32'(D_DONE), 32'd1);
    check("st_drdata", D_RDATA, exp_drdata);
    check("st_frdata", F_RDATA, 32'h2222_2222);
    tick();

    // timeout on a data read
    D_REQ = 1'b1; D_RW = 1'b1; D_MS = 3'b010; D_ADDR = 32'h30;
    tick();
    D_REQ = 1'b0;
    mov_cycles = 0;
    for (int i = 0; i < 40 && MEM_MOV; i++) begin
      mov_cycles++;
      tick();
    end
    check("to_mov_cycles", 32'(mov_cycles), 32'd16);
    check("to_err", 32'(ERR), 32'd1);
    check("to_ddone", 32'(D_DONE), 32'd1);
    check("to_errsrc", 32'(ERR_SRC), 32'd1);
    check("to_drdata", D_RDATA, exp_drdata);
    tick();
    check("to_err_pulse", 32'(ERR), 32'd0);
    D_REQ = 1'b1; D_ADDR = 32'h40;
    tick();
    D_REQ = 1'b0;
    check("to_next_addr", MEM_ADDR, 32'h40);
    ack(2, 32'h5555_AAAA);
    check("to_next_rdata", D_RDATA, 32'h5555_AAAA);
    check("to_next_err", 32'(ERR), 32'd0);
    tick();

    // MOC on the timeout edge
    D_REQ = 1'b1; D_ADDR = 32'h44;
    tick();
    D_REQ = 1'b0;
    ack(15, 32'h0BAD_F00D);
    check("edge_ddone", 32'(D_DONE), 32'd1);
    check("edge_err", 32'(ERR), 32'd0);
    check("edge_rdata", D_RDATA, 32'h0BAD_F00D);
    check("edge_errsrc", 32'(ERR_SRC), 32'd1);
    tick();

    // reset mid-access, then a tie
    F_REQ = 1'b1; F_ADDR = 32'h50;
    tick();
    F_REQ = 1'b0;
    check("mid_mov", 32'(MEM_MOV), 32'd1);
    #2;
    RESET = 1'b0;
    #1;
    check("mid_mov_async", 32'(MEM_MOV), 32'd0);
    check("mid_errsrc", 32'(ERR_SRC), 32'd0);
    check("mid_drdata", D_RDATA, 32'd0);
    tick();
    check("mid_no_fdone", 32'(F_DONE), 32'd0);
    F_REQ = 1'b1; F_ADDR = 32'h60;
    D_REQ = 1'b1; D_RW = 1'b1; D_ADDR = 32'h70;
    RESET = 1'b1;
    tick();
    check("mid_tie_addr", MEM_ADDR, 32'h70);
    check("mid_tie_fdone", 32'(F_DONE), 32'd0);
    F_REQ = 1'b0; D_REQ = 1'b0;
    ack(0, 32'h7777_0000);
    check("mid_tie_ddone", 32'(D_DONE), 32'd1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
